// File: rtl/frogger_pkg.sv
// frogger_pkg: shared grid constants, position type and move decoding for the Frogger core
package frogger_pkg;
    localparam int GRID = 16;
    localparam logic [3:0] START_ROW = 4'd15;
    localparam logic [3:0] START_COL = 4'd7;
    localparam logic [1:0] LIVES_INIT = 2'd3;
    localparam logic [15:0] LANE_INIT = 16'h0C66;
    localparam logic [15:0] SAFE_ROWS = 16'b1000_0000_1000_0001;
    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } pos_t;
    localparam pos_t START_POS = '{row: START_ROW, col: START_COL};
    typedef enum logic {PLAY, OVER} game_state_t;
    typedef enum logic [2:0] {MV_NONE, MV_UP, MV_DOWN, MV_LEFT, MV_RIGHT} move_t;
    function automatic move_t pick_move(input logic up, input logic down, input logic left, input logic right);
        return up ? MV_UP : down ? MV_DOWN : left ? MV_LEFT : right ? MV_RIGHT : MV_NONE;
    endfunction
endpackage

// File: rtl/frogger_game_if.sv
// frogger_game_if: player controls in, LED frame and seven-segment digits out
interface frogger_game_if;
    logic [2:0] speed;
    logic move_up;
    logic move_down;
    logic move_left;
    logic move_right;
    logic [15:0][15:0] red_pixels;
    logic [15:0][15:0] green_pixels;
    logic [6:0] HEX0;
    logic [6:0] HEX5;
    modport master (
        output speed, move_up, move_down, move_left, move_right,
        input red_pixels, green_pixels, HEX0, HEX5
    );
    modport slave (
        input speed, move_up, move_down, move_left, move_right,
        output red_pixels, green_pixels, HEX0, HEX5
    );
endinterface

// File: rtl/frogger_game_seg7_digit.sv
// seg7_digit: decimal digit to active-low {g,f,e,d,c,b,a} pattern, blank above 9
module seg7_digit (
    input  logic [3:0] value,
    output logic [6:0] seg
);
    always_comb begin
        case (value)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    end
endmodule

// File: rtl/frogger_game.sv
// frogger_game: frog, scrolling car lanes, score and lives, rendered to a 16x16 frame
module frogger_game
    import frogger_pkg::*;
#(
    parameter int TICK_BASE = 2048
) (
    input logic clk,
    input logic reset,
    frogger_game_if.slave io
);
    localparam int CW = $clog2(8 * TICK_BASE);
    game_state_t state, state_d;
    pos_t frog, frog_d;
    logic [3:0] score, score_d;
    logic [1:0] lives, lives_d;
    logic [CW-1:0] cnt, limit;
    logic [15:0][15:0] lanes, green;
    logic run, tick, collide;
    move_t mv;
    assign run = io.speed != 3'd0 && state == PLAY;
    assign limit = CW'((8 - int'(io.speed)) * TICK_BASE - 1);
    assign tick = run && cnt >= limit;
    assign collide = lanes[frog.row][frog.col];
    assign mv = pick_move(io.move_up, io.move_down, io.move_left, io.move_right);
    always_comb begin
        state_d = state;
        frog_d = frog;
        score_d = score;
        lives_d = lives;
        if (state == PLAY) begin
            if (collide) begin
                lives_d = lives - 2'd1;
                frog_d = START_POS;
                state_d = lives == 2'd1 ? OVER : PLAY;
            end else if (frog.row == 4'd0) begin
                score_d = score == 4'd9 ? 4'd0 : score + 4'd1;
                frog_d = START_POS;
            end else begin
                frog_d.row = mv == MV_UP && frog.row != 4'd0 ? frog.row - 4'd1 :
                             mv == MV_DOWN && frog.row != 4'd15 ? frog.row + 4'd1 : frog.row;
                frog_d.col = mv == MV_LEFT && frog.col != 4'd0 ? frog.col - 4'd1 :
                             mv == MV_RIGHT && frog.col != 4'd15 ? frog.col + 4'd1 : frog.col;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= PLAY;
            frog <= START_POS;
            score <= 4'd0;
            lives <= LIVES_INIT;
            cnt <= '0;
            for (int r = 0; r < GRID; r++) lanes[r] <= SAFE_ROWS[r] ? 16'h0 : LANE_INIT;
        end else begin
            state <= state_d;
            frog <= frog_d;
            score <= score_d;
            lives <= lives_d;
            cnt <= !run ? cnt : tick ? '0 : cnt + 1'b1;
            // even lanes scroll toward higher columns, odd lanes toward lower
            if (tick)
                for (int r = 0; r < GRID; r++)
                    lanes[r] <= r[0] ? {lanes[r][0], lanes[r][15:1]} : {lanes[r][14:0], lanes[r][15]};
        end
    end
    always_comb begin
        green = '0;
        green[frog.row][frog.col] = 1'b1;
    end
    assign io.red_pixels = lanes;
    assign io.green_pixels = green;
    seg7_digit u_score (.value(score), .seg(io.HEX0));
    seg7_digit u_lives (.value({2'b00, lives}), .seg(io.HEX5));
endmodule

// File: tb/tb_frogger_game.sv
// tb_frogger_game: scoreboard bench, game-rule reference model against the Frogger core
module tb_frogger_game;
    localparam int TB = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    frogger_game_if io();
    frogger_game #(.TICK_BASE(TB)) dut (.clk(clk), .reset(reset), .io(io.slave));
    typedef struct {
        logic [255:0] red;
        logic [255:0] green;
        logic [6:0] h0;
        logic [6:0] h5;
    } exp_t;
    exp_t q[$];
    int compared = 0;
    int mismatched = 0;
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int m_row, m_col, m_score, m_lives, m_cnt, m_shifts;
    bit m_over;
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [15:0] lane_val(input int r);
        logic [15:0] v = 16'h0C66;
        int k = m_shifts % 16;
        if (r == 0 || r == 7 || r == 15) return 16'h0;
        return (r % 2 == 0) ? ((v << k) | (v >> (16 - k))) : ((v >> k) | (v << (16 - k)));
    endfunction
    function automatic exp_t snapshot();
        exp_t e;
        for (int r = 0; r < 16; r++) e.red[r*16 +: 16] = lane_val(r);
        e.green = '0;
        e.green[m_row*16 + m_col] = 1'b1;
        e.h0 = seg_tab[m_score];
        e.h5 = seg_tab[m_lives];
        return e;
    endfunction
    task automatic model_reset();
        m_row = 15; m_col = 7; m_score = 0; m_lives = 3; m_cnt = 0; m_shifts = 0; m_over = 0;
    endtask
    task automatic model_step(input int spd, input bit u, input bit d, input bit l, input bit r);
        logic [15:0] lane = lane_val(m_row);
        bit hit = lane[m_col];
        if (spd != 0 && !m_over) begin
            if (m_cnt >= (8 - spd) * TB - 1) begin
                m_cnt = 0;
                m_shifts++;
            end else m_cnt++;
        end
        if (m_over) return;
        if (hit) begin
            m_lives--;
            m_row = 15; m_col = 7;
            if (m_lives == 0) m_over = 1;
        end else if (m_row == 0) begin
            m_score = (m_score + 1) % 10;
            m_row = 15; m_col = 7;
        end else if (u) begin
            if (m_row > 0) m_row--;
        end else if (d) begin
            if (m_row < 15) m_row++;
        end else if (l) begin
            if (m_col > 0) m_col--;
        end else if (r) begin
            if (m_col < 15) m_col++;
        end
    endtask
    task automatic step(input int spd, input bit u, input bit d, input bit l, input bit r);
        @(negedge clk);
        io.speed = 3'(spd);
        io.move_up = u; io.move_down = d; io.move_left = l; io.move_right = r;
        if (reset) model_step(spd, u, d, l, r);
        q.push_back(snapshot());
    endtask
    task automatic settle();
        @(posedge clk);
        #2;
    endtask
    task automatic do_reset();
        logic [255:0] start = '0;
        start[15*16 + 7] = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        io.move_up = 1'($urandom); io.move_left = 1'($urandom);
        model_reset();
        #1;
        check("reset_async_green", io.green_pixels, start);
        check("reset_async_hex5", io.HEX5, 7'h30);
        repeat (2) step(0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("red", io.red_pixels, e.red);
                check("green", io.green_pixels, e.green);
                check("hex0", io.HEX0, e.h0);
                check("hex5", io.HEX5, e.h5);
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        logic [255:0] g;
        logic [6:0] lives_seg [3] = '{7'h24, 7'h79, 7'h40};
        int spd;
        logic [3:0] b;
        io.speed = 3'd0;
        io.move_up = 0; io.move_down = 0; io.move_left = 0; io.move_right = 0;
        do_reset();
        settle();
        g = '0; g[15*16 + 7] = 1'b1;
        check("init_green", io.green_pixels, g);
        check("init_row14", io.red_pixels[14], 16'h0C66);
        check("init_row7", io.red_pixels[7], 16'h0);
        check("init_hex0", io.HEX0, 7'h40);
        check("init_hex5", io.HEX5, 7'h30);
        repeat (15) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        settle();
        check("goal_hex0", io.HEX0, 7'h79);
        check("goal_hex5", io.HEX5, 7'h30);
        check("goal_green", io.green_pixels, g);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (8) begin
            step(0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0);
        end
        settle();
        g = '0; g[15*16 + 15] = 1'b1;
        check("edge_right", io.green_pixels, g);
        repeat (8) begin
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 0, 0);
            settle();
            check("crash_hex5", io.HEX5, lives_seg[i]);
        end
        for (int i = 0; i < 40; i++) begin
            b = 4'($urandom);
            step(7, b[0], b[1], b[2], b[3]);
        end
        settle();
        g = '0; g[15*16 + 7] = 1'b1;
        check("over_green", io.green_pixels, g);
        check("over_row14", io.red_pixels[14], 16'h0C66);
        do_reset();
        repeat (4) step(7, 0, 0, 0, 0);
        settle();
        check("tick_row14", io.red_pixels[14], 16'h18CC);
        check("tick_row13", io.red_pixels[13], 16'h0633);
        do_reset();
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        settle();
        g = '0; g[14*16 + 7] = 1'b1;
        check("prio_up", io.green_pixels, g);
        for (int i = 0; i < 20; i++) begin
            b = 4'($urandom);
            step(3, b[0], b[1], b[2], b[3]);
        end
        repeat (6) begin
            do_reset();
            spd = $urandom_range(0, 7);
            for (int i = 0; i < 300; i++) begin
                if (i % 60 == 0) spd = $urandom_range(0, 7);
                b = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                step(spd, b[0], b[1], b[2], b[3]);
            end
        end
        settle();
        check("queue_drained", 256'(q.size()), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
